serial_word_receiver: RTL
=========================

# serial_word_receiver

Downstream stage of the transmitting device: deserializes the frames it drives onto its serial line, recovers each word and the index of the queue it came from, and presents them on a one-entry valid/ready output register. It detects parity and framing errors and output overflow. It sits between the transmitter's serial output and the display/consumer logic (HEX decoder, LEDR status).

## Interface
- WORD_SIZE, 4, data bits per frame
- SOURCE_WIDTH, 4, bits of source (queue) index per frame
- CLOCKS_PER_BIT, 4, clock cycles per serial bit; must be even, at least 4

- clock  in  1  system clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- serial_in  in  1  serial line from the transmitter; idle high
- data_out  out  WORD_SIZE  received word
- source_out  out  SOURCE_WIDTH  received source index
- data_valid  out  1  data_out/source_out hold an unconsumed frame
- data_ready  in  1  consumer accepts the frame when data_valid && data_ready
- parity_error  out  1  one-cycle pulse: frame dropped on parity mismatch
- framing_error  out  1  one-cycle pulse: frame dropped because stop bit was 0
- overflow  out  1  one-cycle pulse: good frame dropped because the output register was full
- busy  out  1  high whenever the FSM is not IDLE

## Operation
- serial_in passes through a 2-flop synchronizer; all logic uses the synchronized bit `rx`.
- Frame, in order: start (0), SOURCE_WIDTH index bits LSB first, WORD_SIZE data bits LSB first, parity bit (even parity over index+data; PARITY_CHECK_EN only), stop (1).
- Bit counter `tick` counts 0..CLOCKS_PER_BIT-1. Sample point is `tick == CLOCKS_PER_BIT/2 - 1`, measured from the start edge.
- FSM states and transitions:
  - IDLE: waits for rx==0 -> START, tick cleared.
  - START: at the half-bit point, rx==1 means a glitch -> IDLE with no error. rx==0 -> ID with tick restarted, so later samples land mid-bit.
  - ID: SOURCE_WIDTH samples shifted into an index register -> DATA.
  - DATA: WORD_SIZE samples -> PARITY (or STOP without the macro).
  - PARITY: one sample, parity checked -> STOP.
  - STOP: one sample.
    - rx==0: framing_error pulse, frame dropped -> WAIT_IDLE.
    - Otherwise, with a parity failure: parity_error pulse, frame dropped -> IDLE.
    - Otherwise, the frame is delivered -> IDLE.
  - WAIT_IDLE: stays until rx==1 -> IDLE. No start is detected while in this state.
- Delivery:
  - If data_valid==0, or data_ready==1 in the same cycle, data_out/source_out load and data_valid=1.
  - Otherwise overflow pulses and the held frame is kept unchanged.
- Consumption: data_valid && data_ready && no load in the same cycle -> data_valid=0. data_out/source_out hold their last value.
- Framing error takes priority over parity error. Only one error pulse fires per frame.

## Timing
- Reset values: data_out=0, source_out=0, data_valid=0, parity_error=0, framing_error=0, overflow=0, busy=0, FSM=IDLE, synchronizer flops=1.
- Reset mid-frame aborts the frame; nothing is delivered and no error pulses.
- Synchronizer delay is 2 cycles.
- data_valid rises 1 cycle after the stop-bit sample edge, i.e. about 2 + (frame_bits-1)·CLOCKS_PER_BIT + CLOCKS_PER_BIT/2 + 1 cycles after the serial_in falling edge.
- Error and overflow pulses come out in that same cycle and last exactly 1 cycle.
- Back-to-back frames: a new start is recognized in the first IDLE cycle after STOP. The transmitter's stop bit (≥ half a bit remaining) guarantees the line is high at that point.
- data_valid never drops without a handshake. No combinational path from data_ready to data_valid.

## Configuration
- PARITY_CHECK_EN defined: frames carry the parity bit, the PARITY state exists, and parity_error is active.
- PARITY_CHECK_EN undefined: there is no parity bit in the frame, STOP follows DATA directly, and parity_error is tied to 0.

## Test plan
Defaults: WORD_SIZE=4, SOURCE_WIDTH=4, CLOCKS_PER_BIT=4, macro defined.
- Reset: assert reset mid-frame -> all outputs 0 at once, busy=0; the next clean frame is received correctly.
- Single frame: source 3, data 4'hA, correct parity, data_ready=1 -> data_valid high 1 cycle, source_out=3, data_out=4'hA, no error pulses.
- Parity: same frame with the parity bit flipped -> parity_error one pulse, data_valid stays 0.
- Framing: stop bit 0, line held low 3 bits, then high -> framing_error one pulse. No start is detected until the line returns high, then the next frame (source 9, data 4'h5) is received.
- Overflow: data_ready=0, send (1, 4'h1) then (2, 4'h2) -> second frame gives an overflow pulse; data_out stays 4'h1. Raise data_ready in the cycle a third frame (5, 4'h7) completes -> no overflow; the register holds (5, 4'h7) with data_valid=1.
- Glitch: a 1-cycle low pulse on serial_in -> returns to IDLE, no outputs or pulses. Build without PARITY_CHECK_EN, send (0, 4'hF) -> received correctly in a frame one bit shorter.

Source files
------------

// File: rtl/serial_word_receiver.sv
// serial_word_receiver
// Deserializes frames from the transmitter's serial line into a word plus the
// index of the queue it came from, and holds the result in a one-entry
// valid/ready output register. Reports parity errors, framing errors and
// output overflow as single-cycle pulses.
//
// Frame: start(0), SOURCE_WIDTH index bits LSB first, WORD_SIZE data bits
// LSB first, [even parity over index+data], stop(1).
//
// Build option: define PARITY_CHECK_EN to carry and check the parity bit.
// Without it the frame has no parity bit and parity_error is tied low.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | line idle, waiting for rx low (start edge)
// START     | counting to mid start bit; high there means a glitch
// ID        | sampling SOURCE_WIDTH index bits
// DATA      | sampling WORD_SIZE data bits
// PARITY    | sampling the parity bit (PARITY_CHECK_EN only)
// STOP      | sampling the stop bit; deliver, drop or flag the frame
// WAIT_IDLE | after a framing error, wait for the line to return high
`timescale 1ns/1ps

module serial_word_receiver #(
    parameter int WORD_SIZE      = 4,
    parameter int SOURCE_WIDTH   = 4,
    parameter int CLOCKS_PER_BIT = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    serial_in,
    output logic [WORD_SIZE-1:0]    data_out,
    output logic [SOURCE_WIDTH-1:0] source_out,
    output logic                    data_valid,
    input  logic                    data_ready,
    output logic                    parity_error,
    output logic                    framing_error,
    output logic                    overflow,
    output logic                    busy
);

    localparam int TICK_W    = (CLOCKS_PER_BIT > 2) ? $clog2(CLOCKS_PER_BIT) : 1;
    localparam int MAX_FIELD = (WORD_SIZE > SOURCE_WIDTH) ? WORD_SIZE : SOURCE_WIDTH;
    localparam int CNT_W     = $clog2(MAX_FIELD + 1);

    localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(CLOCKS_PER_BIT / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLOCKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  ID_LAST   = CNT_W'(SOURCE_WIDTH - 1);
    localparam logic [CNT_W-1:0]  DATA_LAST = CNT_W'(WORD_SIZE - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_ID        = 3'd2,
        S_DATA      = 3'd3,
`ifdef PARITY_CHECK_EN
        S_PARITY    = 3'd4,
`endif
        S_STOP      = 3'd5,
        S_WAIT_IDLE = 3'd6
    } state_t;

    state_t                  state_q, state_d;
    logic                    rx_meta_q, rx_meta_d;
    logic                    rx_sync_q, rx_sync_d;
    logic [TICK_W-1:0]       tick_q, tick_d;
    logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic [SOURCE_WIDTH-1:0] id_sh_q, id_sh_d;
    logic [WORD_SIZE-1:0]    data_sh_q, data_sh_d;
    logic [WORD_SIZE-1:0]    data_out_q, data_out_d;
    logic [SOURCE_WIDTH-1:0] source_out_q, source_out_d;
    logic                    data_valid_q, data_valid_d;
    logic                    framing_error_q, framing_error_d;
    logic                    overflow_q, overflow_d;
`ifdef PARITY_CHECK_EN
    logic                    par_acc_q, par_acc_d;
    logic                    par_bad_q, par_bad_d;
    logic                    parity_error_q, parity_error_d;
`endif

    logic rx;
    logic sample;
    logic deliver;

    assign rx = rx_sync_q;

    // State, synchronizer, shift registers and output register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q         <= S_IDLE;
            rx_meta_q       <= 1'b1;
            rx_sync_q       <= 1'b1;
            tick_q          <= '0;
            bit_cnt_q       <= '0;
            id_sh_q         <= '0;
            data_sh_q       <= '0;
            data_out_q      <= '0;
            source_out_q    <= '0;
            data_valid_q    <= 1'b0;
            framing_error_q <= 1'b0;
            overflow_q      <= 1'b0;
`ifdef PARITY_CHECK_EN
            par_acc_q       <= 1'b0;
            par_bad_q       <= 1'b0;
            parity_error_q  <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            rx_meta_q       <= rx_meta_d;
            rx_sync_q       <= rx_sync_d;
            tick_q          <= tick_d;
            bit_cnt_q       <= bit_cnt_d;
            id_sh_q         <= id_sh_d;
            data_sh_q       <= data_sh_d;
            data_out_q      <= data_out_d;
            source_out_q    <= source_out_d;
            data_valid_q    <= data_valid_d;
            framing_error_q <= framing_error_d;
            overflow_q      <= overflow_d;
`ifdef PARITY_CHECK_EN
            par_acc_q       <= par_acc_d;
            par_bad_q       <= par_bad_d;
            parity_error_q  <= parity_error_d;
`endif
        end
    end

    // Next-state, bit sampling and output-register handshake.
    always_comb begin
        state_d         = state_q;
        rx_meta_d       = serial_in;
        rx_sync_d       = rx_meta_q;
        tick_d          = tick_q;
        bit_cnt_d       = bit_cnt_q;
        id_sh_d         = id_sh_q;
        data_sh_d       = data_sh_q;
        data_out_d      = data_out_q;
        source_out_d    = source_out_q;
        data_valid_d    = data_valid_q;
        framing_error_d = 1'b0;
        overflow_d      = 1'b0;
        deliver         = 1'b0;
`ifdef PARITY_CHECK_EN
        par_acc_d       = par_acc_q;
        par_bad_d       = par_bad_q;
        parity_error_d  = 1'b0;
`endif
        // After the start-bit restart, the last tick of each bit period is mid-bit.
        sample = (tick_q == TICK_LAST);

        case (state_q)
            S_IDLE: begin
                tick_d    = '0;
                bit_cnt_d = '0;
                if (!rx) begin
                    state_d = S_START;
                end
            end

            S_START: begin
                if (tick_q == TICK_HALF) begin
                    tick_d    = '0;
                    bit_cnt_d = '0;
                    if (rx) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_ID;
`ifdef PARITY_CHECK_EN
                        par_acc_d = 1'b0;
                        par_bad_d = 1'b0;
`endif
                    end
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end

            S_ID: begin
                tick_d = sample ? '0 : tick_q + 1'b1;
                if (sample) begin
                    id_sh_d = (id_sh_q >> 1) | (SOURCE_WIDTH'(rx) << (SOURCE_WIDTH - 1));
`ifdef PARITY_CHECK_EN
                    par_acc_d = par_acc_q ^ rx;
`endif
                    if (bit_cnt_q == ID_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = S_DATA;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end

            S_DATA: begin
                tick_d = sample ? '0 : tick_q + 1'b1;
                if (sample) begin
                    data_sh_d = (data_sh_q >> 1) | (WORD_SIZE'(rx) << (WORD_SIZE - 1));
`ifdef PARITY_CHECK_EN
                    par_acc_d = par_acc_q ^ rx;
`endif
                    if (bit_cnt_q == DATA_LAST) begin
                        bit_cnt_d = '0;
`ifdef PARITY_CHECK_EN
                        state_d   = S_PARITY;
`else
                        state_d   = S_STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end

`ifdef PARITY_CHECK_EN
            S_PARITY: begin
                tick_d = sample ? '0 : tick_q + 1'b1;
                if (sample) begin
                    // Even parity: index, data and parity bit XOR to zero.
                    par_bad_d = par_acc_q ^ rx;
                    state_d   = S_STOP;
                end
            end
`endif

            S_STOP: begin
                tick_d = sample ? '0 : tick_q + 1'b1;
                if (sample) begin
                    // A low stop bit wins over a parity failure.
                    if (!rx) begin
                        framing_error_d = 1'b1;
                        state_d         = S_WAIT_IDLE;
                    end
`ifdef PARITY_CHECK_EN
                    else if (par_bad_q) begin
                        parity_error_d = 1'b1;
                        state_d        = S_IDLE;
                    end
`endif
                    else begin
                        deliver = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end

            S_WAIT_IDLE: begin
                tick_d = '0;
                if (rx) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A load may coincide with the consumer taking the held frame.
        if (deliver) begin
            if (!data_valid_q || data_ready) begin
                data_out_d   = data_sh_d;
                source_out_d = id_sh_d;
                data_valid_d = 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end else if (data_valid_q && data_ready) begin
            data_valid_d = 1'b0;
        end
    end

    assign data_out      = data_out_q;
    assign source_out    = source_out_q;
    assign data_valid    = data_valid_q;
    assign framing_error = framing_error_q;
    assign overflow      = overflow_q;
    assign busy          = (state_q != S_IDLE);
`ifdef PARITY_CHECK_EN
    assign parity_error  = parity_error_q;
`else
    assign parity_error  = 1'b0;
`endif

endmodule
